alu_ctrl_sequencer: RTL and testbench

- Upstream control stage for the adiabatic ALU: accepts one 16-bit instruction at a time, decodes it into the ALU static control levels and the immediate operand, then starts one Bennett clock sweep.
- Holds every control output frozen for the whole compute/restore sweep, until the Bennett generator reports completion on inst_flag; only then accepts the next instruction.
- Runs on the conventional logic clock that also drives bennett_clock.

---
 rtl/alu_ctrl_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_alu_ctrl_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_sequencer.sv
// Control sequencer for the adiabatic ALU: decodes one instruction, launches a
// Bennett sweep, and holds the ALU control levels frozen until the sweep completes.
module alu_ctrl_sequencer #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      instr_in,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic             inst_flag,
  output logic             bclk_start,
  output logic [1:0]       alu_control,
  output logic             a_mux,
  output logic [1:0]       b_mux,
  output logic             adder_cin,
  output logic             sub,
  output logic             stl,
  output logic [1:0]       mux3,
  output logic [15:0]      imm,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic             err_timeout,
  output logic [CNT_W-1:0] sweep_cycles
);

  localparam int unsigned IMM_W = 16;
  localparam int unsigned OPC_W = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [1:0] alu_control;
    logic       a_mux;
    logic [1:0] b_mux;
    logic       adder_cin;
    logic       sub;
    logic       stl;
    logic [1:0] mux3;
  } ctrl_t;

  state_t           state_q, state_d;
  ctrl_t            ctrl_q, ctrl_d;
  ctrl_t            dec_ctrl;
  logic             dec_legal;
  logic [OPC_W-1:0] opcode;
  logic [IMM_W-1:0] imm_d;
  logic [IMM_W-1:0] imm_sext;
  logic             bclk_start_d;
  logic             done_d;
  logic             illegal_d;
  logic             err_timeout_d;
  logic [CNT_W-1:0] sweep_cycles_d;
  logic             unused_bits;

  assign opcode      = instr_in[15:12];
  assign imm_sext    = {{8{instr_in[7]}}, instr_in[7:0]};
  assign unused_bits = ^instr_in[11:8];

  assign alu_control = ctrl_q.alu_control;
  assign a_mux       = ctrl_q.a_mux;
  assign b_mux       = ctrl_q.b_mux;
  assign adder_cin   = ctrl_q.adder_cin;
  assign sub         = ctrl_q.sub;
  assign stl         = ctrl_q.stl;
  assign mux3        = ctrl_q.mux3;

  // Opcode decode into static ALU control levels
  always_comb begin
    dec_ctrl  = '0;
    dec_legal = 1'b1;
    case (opcode)
      4'h0: dec_ctrl = '0;
      4'h1: begin
        dec_ctrl.b_mux     = 2'b01;
        dec_ctrl.adder_cin = 1'b1;
        dec_ctrl.sub       = 1'b1;
      end
      4'h2: begin
        dec_ctrl.alu_control = 2'b01;
        dec_ctrl.mux3        = 2'b01;
      end
      4'h3: begin
        dec_ctrl.alu_control = 2'b10;
        dec_ctrl.mux3        = 2'b01;
      end
      4'h4: begin
        dec_ctrl.alu_control = 2'b11;
        dec_ctrl.mux3        = 2'b01;
      end
      4'h5: begin
        dec_ctrl.b_mux     = 2'b01;
        dec_ctrl.adder_cin = 1'b1;
        dec_ctrl.sub       = 1'b1;
        dec_ctrl.stl       = 1'b1;
        dec_ctrl.mux3      = 2'b10;
      end
      4'h6: dec_ctrl.b_mux = 2'b10;
      4'h7: begin
        dec_ctrl.a_mux = 1'b1;
        dec_ctrl.b_mux = 2'b10;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_d        = state_q;
    ctrl_d         = ctrl_q;
    imm_d          = imm;
    bclk_start_d   = 1'b0;
    done_d         = 1'b0;
    illegal_d      = illegal;
    err_timeout_d  = err_timeout;
    sweep_cycles_d = sweep_cycles;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          imm_d          = imm_sext;
          illegal_d      = ~dec_legal;
          err_timeout_d  = 1'b0;
          sweep_cycles_d = '0;
          if (dec_legal) begin
            ctrl_d       = dec_ctrl;
            bclk_start_d = 1'b1;
            state_d      = S_ISSUE;
          end else begin
            ctrl_d  = '0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_ISSUE: begin
        sweep_cycles_d = CNT_W'(1);
        state_d        = S_RUN;
      end
      S_RUN: begin
        // Completion beats timeout when both land in the same cycle
        if (inst_flag) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (sweep_cycles == CNT_W'(TIMEOUT)) begin
          err_timeout_d = 1'b1;
          done_d        = 1'b1;
          state_d       = S_DONE;
        end else begin
          sweep_cycles_d = sweep_cycles + CNT_W'(1);
        end
      end
      S_DONE: begin
        ctrl_d  = '0;
        imm_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ctrl_q       <= '0;
      imm          <= '0;
      bclk_start   <= 1'b0;
      done         <= 1'b0;
      illegal      <= 1'b0;
      err_timeout  <= 1'b0;
      sweep_cycles <= '0;
      instr_ready  <= 1'b1;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      ctrl_q       <= ctrl_d;
      imm          <= imm_d;
      bclk_start   <= bclk_start_d;
      done         <= done_d;
      illegal      <= illegal_d;
      err_timeout  <= err_timeout_d;
      sweep_cycles <= sweep_cycles_d;
      instr_ready  <= (state_d == S_IDLE);
      busy         <= (state_d != S_IDLE);
    end
  end

endmodule

// File: tb/tb_alu_ctrl_sequencer.sv
// Scoreboard bench for alu_ctrl_sequencer: directed instructions push expected
// completions; a negedge monitor checks held controls and each done pulse.
module tb_alu_ctrl_sequencer;

  logic        clk;
  logic        reset;
  logic [15:0] instr_in;
  logic        instr_valid;
  logic        instr_ready;
  logic        inst_flag;
  logic        bclk_start;
  logic [1:0]  alu_control;
  logic        a_mux;
  logic [1:0]  b_mux;
  logic        adder_cin;
  logic        sub;
  logic        stl;
  logic [1:0]  mux3;
  logic [15:0] imm;
  logic        busy;
  logic        done;
  logic        illegal;
  logic        err_timeout;
  logic [7:0]  sweep_cycles;

  alu_ctrl_sequencer #(.TIMEOUT(64), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .instr_in(instr_in), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .inst_flag(inst_flag), .bclk_start(bclk_start),
    .alu_control(alu_control), .a_mux(a_mux), .b_mux(b_mux), .adder_cin(adder_cin),
    .sub(sub), .stl(stl), .mux3(mux3), .imm(imm), .busy(busy), .done(done),
    .illegal(illegal), .err_timeout(err_timeout), .sweep_cycles(sweep_cycles)
  );

  typedef struct {
    logic [10:0] ctrl;
    logic [15:0] imm;
    logic        ill;
    logic        err;
    logic [7:0]  sweep;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   bclk_cnt = 0;
  int   done_cnt = 0;

  logic [10:0] ctrl_act;
  assign ctrl_act = {alu_control, a_mux, b_mux, adder_cin, sub, stl, mux3};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // {alu_control, a_mux, b_mux, adder_cin, sub, stl, mux3}
  function automatic logic [10:0] mk(input logic [1:0] alu, input logic a, input logic [1:0] b,
                                     input logic cin, input logic sb, input logic st,
                                     input logic [1:0] m3);
    return {alu, a, b, cin, sb, st, m3};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: held controls while busy, cleared controls in idle, scoreboard on done
  always @(negedge clk) begin
    if (!reset) begin
      if (bclk_start) bclk_cnt++;
      if (busy) begin
        check("ready_low_busy", 32'(instr_ready), 32'd0);
        if (exp_q.size() == 0) begin
          check("busy_without_expectation", 32'(busy), 32'd0);
        end else begin
          check("held_ctrl", 32'(ctrl_act), 32'(exp_q[0].ctrl));
          check("held_imm", 32'(imm), 32'(exp_q[0].imm));
        end
      end else begin
        check("idle_ready", 32'(instr_ready), 32'd1);
        check("idle_ctrl", 32'(ctrl_act), 32'd0);
        check("idle_imm", 32'(imm), 32'd0);
      end
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          check("done_illegal", 32'(illegal), 32'(exp_q[0].ill));
          check("done_err_timeout", 32'(err_timeout), 32'(exp_q[0].err));
          check("done_sweep_cycles", 32'(sweep_cycles), 32'(exp_q[0].sweep));
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // Offer one instruction and drive inst_flag on RUN cycle flag_n (0 = never)
  task automatic run_instr(input logic [15:0] instr, input logic [10:0] ctrl,
                           input logic [15:0] eimm, input logic ill, input logic err,
                           input logic [7:0] sweep, input int flag_n);
    exp_t e;
    int b0, d0, n;
    e.ctrl = ctrl; e.imm = eimm; e.ill = ill; e.err = err; e.sweep = sweep;
    exp_q.push_back(e);
    b0 = bclk_cnt;
    d0 = done_cnt;
    instr_in    = instr;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    if (ill) begin
      check("illegal_done_latency", 32'(done), 32'd1);
      check("illegal_no_bclk", 32'(bclk_start), 32'd0);
      tick();
      check("illegal_bclk_count", 32'(bclk_cnt - b0), 32'd0);
    end else begin
      check("bclk_start_issue", 32'(bclk_start), 32'd1);
      tick();
      if (flag_n != 0) begin
        repeat (flag_n - 1) tick();
        inst_flag = 1'b1;
        tick();
        inst_flag = 1'b0;
        check("done_latency", 32'(done), 32'd1);
      end else begin
        n = 0;
        while (!done && n < 200) begin
          tick();
          n++;
        end
        check("timeout_done_seen", 32'(done), 32'd1);
      end
      tick();
      check("bclk_once", 32'(bclk_cnt - b0), 32'd1);
    end
    check("done_count", 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    int d0;
    exp_t e;
    reset       = 1'b1;
    instr_in    = '0;
    instr_valid = 1'b0;
    inst_flag   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_ready", 32'(instr_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_outs", 32'({bclk_start, done, illegal, err_timeout}), 32'd0);
    check("rst_sweep", 32'(sweep_cycles), 32'd0);

    run_instr(16'h1005, mk(2'b00, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 2'b00), 16'h0005, 1'b0, 1'b0, 8'd12, 12);
    check("sub_ready_after", 32'(instr_ready), 32'd1);
    run_instr(16'h60FF, mk(2'b00, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00), 16'hFFFF, 1'b0, 1'b0, 8'd3, 3);
    run_instr(16'h7010, mk(2'b00, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00), 16'h0010, 1'b0, 1'b0, 8'd5, 5);
    run_instr(16'h5000, mk(2'b00, 1'b0, 2'b01, 1'b1, 1'b1, 1'b1, 2'b10), 16'h0000, 1'b0, 1'b0, 8'd1, 1);
    run_instr(16'h9ABC, 11'd0, 16'hFFBC, 1'b1, 1'b0, 8'd0, 0);
    check("illegal_held", 32'(illegal), 32'd1);
    run_instr(16'h0000, 11'd0, 16'h0000, 1'b0, 1'b1, 8'd64, 0);
    check("timeout_err_held", 32'(err_timeout), 32'd1);
    run_instr(16'h0040, 11'd0, 16'h0040, 1'b0, 1'b0, 8'd64, 64);

    // Two queued instructions with instr_valid held high
    e.ctrl = mk(2'b10, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b01); e.imm = 16'h0004;
    e.ill = 1'b0; e.err = 1'b0; e.sweep = 8'd3;
    exp_q.push_back(e);
    e.ctrl = mk(2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b01); e.imm = 16'hFF83;
    e.sweep = 8'd2;
    exp_q.push_back(e);
    d0 = done_cnt;
    instr_in    = 16'h3004;
    instr_valid = 1'b1;
    tick();
    instr_in = 16'h2083;
    check("b2b_first_issue", 32'(bclk_start), 32'd1);
    tick(); tick(); tick();
    inst_flag = 1'b1;
    tick();
    inst_flag = 1'b0;
    check("b2b_first_done", 32'(done), 32'd1);
    tick();
    check("b2b_idle_gap", 32'(busy), 32'd0);
    tick();
    instr_valid = 1'b0;
    check("b2b_second_issue", 32'(bclk_start), 32'd1);
    tick(); tick();
    inst_flag = 1'b1;
    tick();
    inst_flag = 1'b0;
    check("b2b_second_done", 32'(done), 32'd1);
    tick();
    check("b2b_done_count", 32'(done_cnt - d0), 32'd2);

    // Stray inst_flag in IDLE
    d0 = done_cnt;
    inst_flag = 1'b1;
    tick();
    inst_flag = 1'b0;
    check("stray_busy", 32'(busy), 32'd0);
    check("stray_bclk", 32'(bclk_start), 32'd0);
    tick();
    check("stray_done_count", 32'(done_cnt - d0), 32'd0);

    // Reset during the 5th RUN cycle
    e.ctrl = mk(2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b01); e.imm = 16'hFF80;
    e.ill = 1'b0; e.err = 1'b0; e.sweep = 8'd0;
    exp_q.push_back(e);
    d0 = done_cnt;
    instr_in    = 16'h4080;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    repeat (4) tick();
    check("pre_reset_sweep", 32'(sweep_cycles), 32'd5);
    reset = 1'b1;
    exp_q.delete();
    tick();
    reset = 1'b0;
    check("mid_rst_ready", 32'(instr_ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ctrl", 32'(ctrl_act), 32'd0);
    check("mid_rst_imm", 32'(imm), 32'd0);
    check("mid_rst_outs", 32'({bclk_start, done, illegal, err_timeout}), 32'd0);
    check("mid_rst_sweep", 32'(sweep_cycles), 32'd0);
    inst_flag = 1'b1;
    tick();
    inst_flag = 1'b0;
    tick();
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_done_count", 32'(done_cnt - d0), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
